// File: rtl/temp_monitor.sv
// Windowed temperature averager with persistence-qualified, hysteretic over-temperature alarm.
// Accepts N samples per window over valid/ready, evaluates the average for one cycle, then resumes.
module temp_monitor #(
  parameter int unsigned W       = 8,
  parameter int unsigned N       = 4,
  parameter int unsigned HYST    = 2,
  parameter int unsigned PERSIST = 3,
  localparam int unsigned LN     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          sample_valid,
  input  logic [W-1:0]  sample,
  output logic          sample_ready,
  input  logic [W-1:0]  temp_compare,
  output logic [LN-1:0] ch_idx,
  output logic [W-1:0]  avg,
  output logic          avg_valid,
  output logic          tooHot
);

  localparam int unsigned HCW = $clog2(PERSIST + 1);
  localparam logic [HCW-1:0] PMAX = HCW'(PERSIST);

  typedef enum logic {ACCUM, EVAL} state_t;

  state_t          state_q, state_d;
  logic [W+LN-1:0] acc_q, acc_d;
  logic [LN-1:0]   ch_q, ch_d;
  logic [W-1:0]    avg_q, avg_d;
  logic            avg_valid_q, avg_valid_d;
  logic            hot_q, hot_d;
  logic [HCW-1:0]  hot_cnt_q, hot_cnt_d;

  logic [W-1:0]    avg_new;
  logic [HCW-1:0]  cnt_inc;
  logic            above, below;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      ch_q        <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      hot_q       <= 1'b0;
      hot_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ch_q        <= ch_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      hot_q       <= hot_d;
      hot_cnt_q   <= hot_cnt_d;
    end
  end

  // Comparison is done at W+1 bits so a + HYST cannot wrap.
  always_comb begin
    avg_new = W'(acc_q >> LN);
    above   = avg_new > temp_compare;
    below   = ({1'b0, avg_new} + (W+1)'(HYST)) < {1'b0, temp_compare};
    cnt_inc = (hot_cnt_q == PMAX) ? PMAX : hot_cnt_q + HCW'(1);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ch_d        = ch_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    hot_d       = hot_q;
    hot_cnt_d   = hot_cnt_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d = '0;
          ch_d  = '0;
        end else if (sample_valid) begin
          acc_d = acc_q + (W+LN)'(sample);
          ch_d  = ch_q + LN'(1);
          if (ch_q == LN'(N - 1)) state_d = EVAL;
        end
      end
      EVAL: begin
        avg_d       = avg_new;
        acc_d       = '0;
        avg_valid_d = 1'b1;
        state_d     = ACCUM;
        if (above) begin
          hot_cnt_d = cnt_inc;
          if (cnt_inc == PMAX) hot_d = 1'b1;
        end else begin
          hot_cnt_d = '0;
        end
        if (below) hot_d = 1'b0;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign sample_ready = (state_q == ACCUM);
  assign ch_idx       = ch_q;
  assign avg          = avg_q;
  assign avg_valid    = avg_valid_q;
  assign tooHot       = hot_q;

endmodule
